// File: rtl/ibex_instr_mem_responder_if.sv
// Ibex instruction-fetch bus: req/gnt handshake plus rvalid/err response.
// master = fetch initiator (core prefetch buffer), slave = responder.
interface ibex_instr_mem_responder_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;

  modport master (
    output instr_req,
    output instr_addr,
    input  instr_gnt,
    input  instr_rvalid,
    input  instr_rdata,
    input  instr_err
  );

  modport slave (
    input  instr_req,
    input  instr_addr,
    output instr_gnt,
    output instr_rvalid,
    output instr_rdata,
    output instr_err
  );
endinterface

// File: rtl/ibex_instr_mem_responder.sv
// Instruction-fetch responder in front of a synchronous single-port SRAM.
// Adds GntWait grant wait states and RespDelay response stages, and turns
// out-of-range or misaligned fetches into error responses (no SRAM access).
module ibex_instr_mem_responder #(
  parameter int unsigned MemWords  = 4096,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int unsigned GntWait   = 0,
  parameter int unsigned RespDelay = 0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  ibex_instr_mem_responder_if.slave   bus,
  output logic                        mem_req_o,
  output logic [$clog2(MemWords)-1:0] mem_addr_o,
  input  logic [31:0]                 mem_rdata_i,
  output logic                        busy_o
);

  localparam int unsigned AddrW    = $clog2(MemWords);
  localparam int unsigned Depth    = RespDelay + 1;
  localparam logic [3:0]  GntWaitC = 4'(GntWait);
  // One bit wider than the address so MemWords*4 == 2^32 still fits.
  localparam logic [32:0] MemBytes = 33'(MemWords) << 2;

  logic [3:0]       wcnt_q, wcnt_d;
  logic             gnt;
  logic             req_ok;
  logic [31:0]      offset;
  logic [Depth-1:0] pv_q, pv_d;
  logic [Depth-1:0] pe_q, pe_d;
  logic [31:0]      resp_data;
  logic             rvalid;
  logic             err;

  // Grant once the wait count reaches GntWait; held off while in reset so
  // every output reads 0 during reset even with a request pending.
  always_comb begin
    gnt = bus.instr_req & rst_ni & (wcnt_q == GntWaitC);
  end

  // Wait counter: counts held request cycles, restarts on grant or drop.
  always_comb begin
    wcnt_d = wcnt_q;
    if (!bus.instr_req || gnt) begin
      wcnt_d = '0;
    end else if (wcnt_q < GntWaitC) begin
      wcnt_d = wcnt_q + 4'd1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  // Address decode at grant and SRAM read request for accepted fetches.
  always_comb begin
    offset     = bus.instr_addr - BaseAddr;
    req_ok     = ({1'b0, offset} < MemBytes) && (bus.instr_addr[1:0] == 2'b00);
    mem_req_o  = gnt & req_ok;
    mem_addr_o = '0;
    if (mem_req_o) begin
      mem_addr_o = offset[AddrW+1:2];
    end
  end

  // Response pipeline next state: each grant enters as {valid=1, err=!ok}.
  always_comb begin
    pv_d    = '0;
    pe_d    = '0;
    pv_d[0] = gnt;
    pe_d[0] = gnt & ~req_ok;
    for (int unsigned i = 1; i < Depth; i++) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
  end

  // Response pipeline registers; reset drops any in-flight response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pv_q <= '0;
      pe_q <= '0;
    end else begin
      pv_q <= pv_d;
      pe_q <= pe_d;
    end
  end

  // Read data path: SRAM data arrives one cycle after grant, then travels
  // RespDelay further stages so it lines up with the last valid/err stage.
  if (RespDelay == 0) begin : g_no_delay
    // Data used straight from the SRAM output.
    always_comb begin
      resp_data = mem_rdata_i;
    end
  end else begin : g_delay
    logic [31:0] dat_q [RespDelay];
    logic [31:0] dat_d [RespDelay];

    // Data shift next state.
    always_comb begin
      dat_d[0] = mem_rdata_i;
      for (int unsigned i = 1; i < RespDelay; i++) begin
        dat_d[i] = dat_q[i-1];
      end
    end

    // Data shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < RespDelay; i++) begin
          dat_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < RespDelay; i++) begin
          dat_q[i] <= dat_d[i];
        end
      end
    end

    // Oldest data stage feeds the response.
    always_comb begin
      resp_data = dat_q[RespDelay-1];
    end
  end

  // Bus outputs from the final pipeline stage; rdata is 0 unless rvalid.
  // busy includes the grant cycle itself, since that request is already
  // committed to a response although it has not entered a stage yet.
  always_comb begin
    rvalid           = pv_q[Depth-1] & ~pe_q[Depth-1];
    err              = pv_q[Depth-1] &  pe_q[Depth-1];
    bus.instr_gnt    = gnt;
    bus.instr_rvalid = rvalid;
    bus.instr_err    = err;
    bus.instr_rdata  = rvalid ? resp_data : '0;
    busy_o           = (wcnt_q != '0) | gnt | (|pv_q);
  end

endmodule

// File: tb/tb_ibex_instr_mem_responder.sv
// Bench for ibex_instr_mem_responder: four instances with different latency
// and address-map settings, a shared SRAM image, per-instance scoreboards.
module tb_ibex_instr_mem_responder;

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        rst_d_n = 1'b1;
  int          cyc     = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem [4096];
  exp_t        sb [4][$];

  logic        gn    [4];
  logic        rv    [4];
  logic        er    [4];
  logic [31:0] rd    [4];
  logic        mreq  [4];
  logic [11:0] maddr [4];
  logic [31:0] mrd   [4];
  logic        busy  [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ibex_instr_mem_responder_if if_a ();
  ibex_instr_mem_responder_if if_b ();
  ibex_instr_mem_responder_if if_c ();
  ibex_instr_mem_responder_if if_d ();

  ibex_instr_mem_responder #(.MemWords(4096), .BaseAddr(32'h0), .GntWait(0), .RespDelay(0)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_a), .mem_req_o(mreq[0]), .mem_addr_o(maddr[0]),
    .mem_rdata_i(mrd[0]), .busy_o(busy[0]));
  ibex_instr_mem_responder #(.MemWords(4096), .BaseAddr(32'h0), .GntWait(3), .RespDelay(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_b), .mem_req_o(mreq[1]), .mem_addr_o(maddr[1]),
    .mem_rdata_i(mrd[1]), .busy_o(busy[1]));
  ibex_instr_mem_responder #(.MemWords(4096), .BaseAddr(32'h8000_0000), .GntWait(0), .RespDelay(0)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .bus(if_c), .mem_req_o(mreq[2]), .mem_addr_o(maddr[2]),
    .mem_rdata_i(mrd[2]), .busy_o(busy[2]));
  ibex_instr_mem_responder #(.MemWords(4096), .BaseAddr(32'h0), .GntWait(0), .RespDelay(2)) dut_d (
    .clk_i(clk), .rst_ni(rst_n & rst_d_n), .bus(if_d), .mem_req_o(mreq[3]), .mem_addr_o(maddr[3]),
    .mem_rdata_i(mrd[3]), .busy_o(busy[3]));

  assign gn[0] = if_a.instr_gnt;  assign rv[0] = if_a.instr_rvalid;
  assign er[0] = if_a.instr_err;  assign rd[0] = if_a.instr_rdata;
  assign gn[1] = if_b.instr_gnt;  assign rv[1] = if_b.instr_rvalid;
  assign er[1] = if_b.instr_err;  assign rd[1] = if_b.instr_rdata;
  assign gn[2] = if_c.instr_gnt;  assign rv[2] = if_c.instr_rvalid;
  assign er[2] = if_c.instr_err;  assign rd[2] = if_c.instr_rdata;
  assign gn[3] = if_d.instr_gnt;  assign rv[3] = if_d.instr_rvalid;
  assign er[3] = if_d.instr_err;  assign rd[3] = if_d.instr_rdata;

  // Synchronous SRAM model per instance: data one cycle after the read enable.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mreq[k] === 1'b1) mrd[k] <= mem[maddr[k]];
    end
  end

  // Scoreboard: every response is popped and compared with its expected cycle,
  // kind and data; outside a response rvalid/err/rdata must all be 0.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rv[k] === 1'b1 || er[k] === 1'b1) begin
        if (sb[k].size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected dut%0d cycle %0d: got rvalid=%b err=%b rdata=%h, required no response",
                   k, cyc, rv[k], er[k], rd[k]);
        end else begin
          e = sb[k].pop_front();
          if (cyc !== e.cyc || er[k] !== e.err || rv[k] !== !e.err || rd[k] !== e.data) begin
            n_fail++;
            $display("FAIL resp dut%0d: got cycle %0d rvalid=%b err=%b rdata=%h, required cycle %0d err=%b rdata=%h",
                     k, cyc, rv[k], er[k], rd[k], e.cyc, e.err, e.data);
          end
        end
      end else if ({rv[k], er[k], rd[k]} !== 34'd0) begin
        n_fail++;
        $display("FAIL resp_idle dut%0d cycle %0d: got rvalid=%b err=%b rdata=%h, required all 0",
                 k, cyc, rv[k], er[k], rd[k]);
      end
    end
  end

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    if_a.instr_req = 1'b1; if_a.instr_addr = 32'h4;
    if_d.instr_req = 1'b1; if_d.instr_addr = 32'h8;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({gn[k], rv[k], er[k], rd[k], mreq[k], maddr[k], busy[k]} !== 49'd0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got gnt=%b rvalid=%b err=%b rdata=%h mem_req=%b mem_addr=%h busy=%b, required all 0",
                 k, gn[k], rv[k], er[k], rd[k], mreq[k], maddr[k], busy[k]);
      end
    end
    @(posedge clk); #1;
    if_a.instr_req = 1'b0;
    if_d.instr_req = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic        ok;
    @(posedge clk); #1;
    if_a.instr_req = 1'b1; if_a.instr_addr = 32'h4;
    sb[0].push_back('{cyc + 1, 1'b0, 32'hA5A5_0001});
    @(negedge clk);
    n_checks++;
    if (gn[0] !== 1'b1 || mreq[0] !== 1'b1 || maddr[0] !== 12'd1) begin
      n_fail++;
      $display("FAIL b2b_first_grant: got gnt=%b mem_req=%b mem_addr=%0d, required 1 1 1", gn[0], mreq[0], maddr[0]);
    end
    @(posedge clk); #1;
    if_a.instr_addr = 32'h8;
    sb[0].push_back('{cyc + 1, 1'b0, 32'h0000_0013});
    @(negedge clk);
    n_checks++;
    if (gn[0] !== 1'b1 || mreq[0] !== 1'b1 || maddr[0] !== 12'd2) begin
      n_fail++;
      $display("FAIL b2b_second_grant: got gnt=%b mem_req=%b mem_addr=%0d, required 1 1 2", gn[0], mreq[0], maddr[0]);
    end
    // Mixed stream of in-range, out-of-range and misaligned fetches.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      case (i % 4)
        0, 3:    addr = 32'($urandom_range(0, 4095)) << 2;
        1:       addr = 32'h4000 + (32'($urandom_range(0, 1023)) << 2);
        default: addr = (32'($urandom_range(0, 4095)) << 2) | 32'h2;
      endcase
      ok = (addr < 32'h4000) && (addr[1:0] == 2'b00);
      if_a.instr_addr = addr;
      sb[0].push_back('{cyc + 1, !ok, ok ? mem[addr[13:2]] : 32'h0});
      @(negedge clk);
      n_checks++;
      if (gn[0] !== 1'b1 || mreq[0] !== ok) begin
        n_fail++;
        $display("FAIL b2b_stream_grant addr=%h: got gnt=%b mem_req=%b, required gnt=1 mem_req=%b", addr, gn[0], mreq[0], ok);
      end
    end
    @(posedge clk); #1;
    if_a.instr_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (gn[0] !== 1'b0 || mreq[0] !== 1'b0 || maddr[0] !== 12'd0) begin
      n_fail++;
      $display("FAIL b2b_idle: got gnt=%b mem_req=%b mem_addr=%0d, required 0 0 0", gn[0], mreq[0], maddr[0]);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_grant_wait();
    logic [7:0] pat;
    // Held request: grant on the fourth cycle; addr changes during waits.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if_b.instr_req  = 1'b1;
      if_b.instr_addr = (i == 3) ? 32'h40 : 32'hFFFF_FFF1;
      if (i == 3) sb[1].push_back('{cyc + 1, 1'b0, mem[16]});
      @(negedge clk);
      n_checks++;
      if (gn[1] !== (i == 3) || busy[1] !== (i != 0)) begin
        n_fail++;
        $display("FAIL wait_held step %0d: got gnt=%b busy=%b, required gnt=%b busy=%b",
                 i, gn[1], busy[1], (i == 3), (i != 0));
      end
    end
    @(posedge clk); #1;
    if_b.instr_req = 1'b0;
    repeat (3) @(posedge clk);
    // Dropped after two cycles, re-raised two cycles later: wait restarts.
    pat = 8'b1111_0011;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if_b.instr_req  = pat[i];
      if_b.instr_addr = (i == 7) ? 32'h44 : 32'h0000_0003;
      if (i == 7) sb[1].push_back('{cyc + 1, 1'b0, mem[17]});
      @(negedge clk);
      n_checks++;
      if (gn[1] !== (i == 7)) begin
        n_fail++;
        $display("FAIL wait_restart step %0d: got gnt=%b, required %b", i, gn[1], (i == 7));
      end
    end
    @(posedge clk); #1;
    if_b.instr_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_range_error();
    logic [31:0] addrs [5];
    logic        oks   [5];
    logic [11:0] idxs  [5];
    addrs = '{32'h8000_4000, 32'h7FFF_FFFC, 32'h8000_0002, 32'h8000_3FFC, 32'h8000_0000};
    oks   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    idxs  = '{12'd0, 12'd0, 12'd0, 12'd4095, 12'd0};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if_c.instr_req  = 1'b1;
      if_c.instr_addr = addrs[i];
      sb[2].push_back('{cyc + 1, !oks[i], oks[i] ? mem[idxs[i]] : 32'h0});
      @(negedge clk);
      n_checks++;
      if (gn[2] !== 1'b1 || mreq[2] !== oks[i] || maddr[2] !== idxs[i]) begin
        n_fail++;
        $display("FAIL range addr=%h: got gnt=%b mem_req=%b mem_addr=%0d, required gnt=1 mem_req=%b mem_addr=%0d",
                 addrs[i], gn[2], mreq[2], maddr[2], oks[i], idxs[i]);
      end
    end
    @(posedge clk); #1;
    if_c.instr_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_resp_delay();
    @(negedge clk);
    n_checks++;
    if (busy[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL delay_busy_before: got busy=%b, required 0", busy[3]);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        if_d.instr_req  = 1'b1;
        if_d.instr_addr = 32'h10 + 32'(i * 4);
        sb[3].push_back('{cyc + 3, 1'b0, mem[4 + i]});
      end else begin
        if_d.instr_req = 1'b0;
      end
      @(negedge clk);
      n_checks++;
      if (busy[3] !== (i <= 5) || gn[3] !== (i < 3)) begin
        n_fail++;
        $display("FAIL delay step %0d: got busy=%b gnt=%b, required busy=%b gnt=%b",
                 i, busy[3], gn[3], (i <= 5), (i < 3));
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    if_d.instr_req  = 1'b1;
    if_d.instr_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if (gn[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_grant: got gnt=%b, required 1", gn[3]);
    end
    @(posedge clk); #1;
    rst_d_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({gn[3], rv[3], er[3], rd[3], mreq[3], maddr[3], busy[3]} !== 49'd0) begin
        n_fail++;
        $display("FAIL midflight_reset_outputs %0d: got gnt=%b rvalid=%b err=%b rdata=%h mem_req=%b mem_addr=%h busy=%b, required all 0",
                 i, gn[3], rv[3], er[3], rd[3], mreq[3], maddr[3], busy[3]);
      end
      @(posedge clk);
    end
    #1;
    rst_d_n = 1'b1;
    if_d.instr_req = 1'b0;
    repeat (6) @(posedge clk);
    // Still serves normally after the reset.
    #1;
    if_d.instr_req  = 1'b1;
    if_d.instr_addr = 32'h24;
    sb[3].push_back('{cyc + 3, 1'b0, mem[9]});
    @(posedge clk); #1;
    if_d.instr_req = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[1] = 32'hA5A5_0001;
    mem[2] = 32'h0000_0013;
    if_a.instr_req = 1'b0; if_a.instr_addr = '0;
    if_b.instr_req = 1'b0; if_b.instr_addr = '0;
    if_c.instr_req = 1'b0; if_c.instr_addr = '0;
    if_d.instr_req = 1'b0; if_d.instr_addr = '0;

    test_reset();
    test_back_to_back();
    test_grant_wait();
    test_range_error();
    test_resp_delay();
    test_reset_midflight();

    repeat (4) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (sb[k].size() != 0) begin
        n_fail++;
        $display("FAIL missing_resp dut%0d: got %0d responses still outstanding, required 0", k, sb[k].size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion by time limit, required completion");
    $fatal(1, "timeout");
  end

endmodule
